// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

    // 2'd3 is never entered; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bits needed to count 0..width-1 (at least one bit).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell: two half-adder stages (xor/and) joined by an OR
// on the two partial carries. Purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;   // first half-adder sum (propagate)
    logic g;   // first half-adder carry (generate)
    logic t;   // second half-adder carry

    assign p    = a ^ b;
    assign g    = a & b;
    assign s    = p ^ cin;
    assign t    = p & cin;
    assign cout = g | t;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first. Operands are captured on an accepted
// start, one bit per clock passes through a single full adder and a carry
// flop, and the finished sum/carry are published together with a one-cycle
// done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [CW-1:0]    count;
    logic             c;
    logic             fa_s;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    // Start is only honoured when no addition is in flight.
    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_bit = (state == ST_SHIFT) && (count == CW'(WIDTH - 1));

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_nxt = last_bit ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand/sum shift registers, carry flop, counter, result regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            count     <= '0;
            c         <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            sum_sr <= '0;
            count  <= '0;
            c      <= 1'b0;
        end else if (state == ST_SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
            c      <= fa_cout;
            count  <= count + CW'(1);
            // Publish only the complete result, on the edge that enters DONE.
            if (last_bit) begin
                sum       <= {fa_s, sum_sr[WIDTH-1:1]};
                carry_out <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4). Expected results are pushed
// to a scoreboard queue when a start is accepted and popped on each done pulse.
module tb_serial_adder;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    int               checks;
    int               errors;
    int               n_done;
    int               n_accepted;
    bit               mon_en;
    logic [WIDTH:0]   last_res;
    logic [WIDTH:0]   exp_q[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Scoreboard side: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy || done)
                check("busy_and_done", {30'd0, busy, done} & 32'h3 & {30'd0, busy, busy}
                      & {30'd0, done, done}, 32'd0);
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("done_without_start", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("result", {27'd0, carry_out, sum}, {27'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // One full operation with timing checks. glitch >= 0 pulses start (with
    // different operands) during that SHIFT cycle index; it must be ignored.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int glitch);
        logic [WIDTH:0] e;
        e = model(av, bv);
        a = av;
        b = bv;
        start = 1'b1;
        exp_q.push_back(e);
        n_accepted++;
        @(posedge clk); #1;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        for (int i = 0; i < WIDTH; i++) begin
            start = (i == glitch);
            if (i == glitch) begin
                a = 1;
                b = 1;
            end
            check("busy", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            check("sum_hold", {27'd0, carry_out, sum}, {27'd0, last_res});
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        last_res = e;
        @(posedge clk); #1;
        check("idle_after", {30'd0, busy, done}, 32'd0);
        check("result_held", {27'd0, carry_out, sum}, {27'd0, last_res});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks     = 0;
        errors     = 0;
        n_done     = 0;
        n_accepted = 0;
        mon_en     = 1'b0;
        last_res   = '0;
        rst        = 1'b1;
        start      = 1'b0;
        a          = '0;
        b          = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", {27'd0, carry_out, sum}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Directed operations, including wrap/overflow cases.
        run_op(4'd3, 4'd5, -1);
        run_op(4'd15, 4'd1, -1);
        run_op(4'd15, 4'd15, -1);
        run_op(4'd0, 4'd0, -1);

        // Start pulsed during SHIFT cycle 2 must not disturb 6+7.
        run_op(4'd6, 4'd7, 1);
        check("glitch_pending", 32'(exp_q.size()), 32'd0);

        // Back-to-back: start held through the done cycle.
        a = 4'd9;
        b = 4'd4;
        start = 1'b1;
        exp_q.push_back(model(4'd9, 4'd4));
        n_accepted++;
        @(posedge clk); #1;
        a = 4'd2;
        b = 4'd2;
        for (int i = 0; i < WIDTH; i++) begin
            check("b2b_busy1", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        check("b2b_done1", 32'(done), 32'd1);
        exp_q.push_back(model(4'd2, 4'd2));
        n_accepted++;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_resume", {30'd0, busy, done}, 32'd2);
        check("b2b_hold", {27'd0, carry_out, sum}, 32'd13);
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clk); #1;
            check("b2b_busy2", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        check("b2b_done2", 32'(done), 32'd1);
        @(posedge clk); #1;
        last_res = model(4'd2, 4'd2);

        // Reset aborting an operation in SHIFT cycle 3.
        a = 4'd10;
        b = 4'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state", {30'd0, busy, done}, 32'd0);
        check("abort_outputs", {27'd0, carry_out, sum}, 32'd0);
        last_res = '0;
        repeat (6) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(4'd1, 4'd2, -1);

        // Exhaustive sweep.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            ab = i[7:0];
            run_op(ab[7:4], ab[3:0], -1);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_accepted));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
